// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
// Module : key_pkg
// Desc   : FSM state encodings, timing defaults and width helper shared by the
//          key debouncer channel and array.
// Rev    : 1.0 - initial release
// ============================================================================
package key_pkg;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] IDLE         = 4'b0001;
    localparam logic [STATE_W-1:0] PRESS_FILT   = 4'b0010;
    localparam logic [STATE_W-1:0] DOWN         = 4'b0100;
    localparam logic [STATE_W-1:0] RELEASE_FILT = 4'b1000;

    localparam int DEF_NUM_KEYS     = 4;
    localparam int DEF_DEBOUNCE_CYC = 1_000_000;
    localparam int DEF_LONG_CYC     = 50_000_000;
    localparam bit DEF_ACTIVE_LOW   = 1'b1;

    // Counter width for a range of n cycles, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce_array_if.sv
`default_nettype none
// ============================================================================
// Module : key_debounce_array_if
// Desc   : Raw key pins and debounced state/event strobes of the key array.
// Rev    : 1.0 - initial release
// ============================================================================
interface key_debounce_array_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_in;
    logic [NUM_KEYS-1:0] key_state;
    logic [NUM_KEYS-1:0] press_pulse;
    logic [NUM_KEYS-1:0] release_pulse;
    logic [NUM_KEYS-1:0] long_pulse;

    modport master (
        output key_in,
        input  key_state,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse
    );

    modport slave (
        input  key_in,
        output key_state,
        output press_pulse,
        output release_pulse,
        output long_pulse
    );
endinterface
`default_nettype wire

// File: rtl/key_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module : key_debounce_ch
// Desc   : One key channel: synchroniser, press/release filter FSM and
//          long-press hold timer with registered event strobes.
// Rev    : 1.0 - initial release
// ============================================================================
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int LONG_CYC     = DEF_LONG_CYC,
    parameter bit ACTIVE_LOW   = DEF_ACTIVE_LOW
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic key_i,
    output logic      key_state_o,
    output logic      press_pulse_o,
    output logic      release_pulse_o,
    output logic      long_pulse_o
);

    localparam int            DW       = cnt_width(DEBOUNCE_CYC);
    localparam int            HW       = cnt_width(LONG_CYC);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYC - 1);
    localparam logic [HW-1:0] LONG_HIT = HW'(LONG_CYC - DEBOUNCE_CYC);
    localparam logic [HW-1:0] HOLD_MAX = '1;

    logic               sync1_q, sync2_q;
    logic               p;
    logic [STATE_W-1:0] state_q, state_d;
    logic [DW-1:0]      deb_q, deb_d;
    logic [HW-1:0]      hold_q, hold_d, hold_inc;
    logic               press_q, press_d;
    logic               release_q, release_d;
    logic               long_q, long_d;

    // Synchroniser resets to the idle pin level so reset release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= ACTIVE_LOW;
            sync2_q <= ACTIVE_LOW;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
        end
    end

    assign p        = sync2_q ^ ACTIVE_LOW;
    assign hold_inc = hold_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        deb_d     = deb_q;
        hold_d    = hold_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        case (state_q)
            IDLE: begin
                hold_d = '0;
                if (p) begin
                    state_d = PRESS_FILT;
                    deb_d   = '0;
                end
            end
            PRESS_FILT: begin
                if (!p) begin
                    state_d = IDLE;
                end else if (deb_q == DEB_LAST) begin
                    state_d = DOWN;
                    press_d = 1'b1;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            DOWN: begin
                if (!p) begin
                    state_d = RELEASE_FILT;
                    deb_d   = '0;
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_inc;
                    long_d = (hold_inc == LONG_HIT);
                end
            end
            RELEASE_FILT: begin
                // The hold timer is paused here, so a release bounce resumes it.
                if (p) begin
                    state_d = DOWN;
                end else if (deb_q == DEB_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    hold_d    = '0;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                deb_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            deb_q     <= '0;
            hold_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            deb_q     <= deb_d;
            hold_q    <= hold_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    assign key_state_o     = (state_q == DOWN) || (state_q == RELEASE_FILT);
    assign press_pulse_o   = press_q;
    assign release_pulse_o = release_q;
    assign long_pulse_o    = long_q;

endmodule
`default_nettype wire

// File: rtl/key_debounce_array.sv
`default_nettype none
// ============================================================================
// Module : key_debounce_array
// Desc   : NUM_KEYS (1..32) fully independent debounced key channels.
// Rev    : 1.0 - initial release
// ============================================================================
module key_debounce_array
    import key_pkg::*;
#(
    parameter int NUM_KEYS     = DEF_NUM_KEYS,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int LONG_CYC     = DEF_LONG_CYC,
    parameter bit ACTIVE_LOW   = DEF_ACTIVE_LOW
) (
    input wire logic            clk,
    input wire logic            rst_n,
    key_debounce_array_if.slave kif
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .LONG_CYC     (LONG_CYC),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_ch (
            .clk             (clk),
            .rst_n           (rst_n),
            .key_i           (kif.key_in[i]),
            .key_state_o     (kif.key_state[i]),
            .press_pulse_o   (kif.press_pulse[i]),
            .release_pulse_o (kif.release_pulse[i]),
            .long_pulse_o    (kif.long_pulse[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_array.sv
`default_nettype none
// ============================================================================
// Module : tb_key_debounce_array
// Desc   : Self-checking bench: directed vector table, hand-written corner
//          sequences and randomized key activity against a reference model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_key_debounce_array;

    localparam int NK  = 4;
    localparam int DEB = 8;
    localparam int LNG = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    key_debounce_array_if #(.NUM_KEYS(NK)) kif ();

    key_debounce_array #(
        .NUM_KEYS     (NK),
        .DEBOUNCE_CYC (DEB),
        .LONG_CYC     (LNG),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kif   (kif)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    int cyc     = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: raw pin delayed two samples, then run-length rules.
    bit            m_r1 [NK];
    bit            m_r2 [NK];
    bit            m_deb[NK];
    int            m_run[NK];
    int            m_hold[NK];
    logic [NK-1:0] m_press = '0, m_rel = '0, m_long = '0, m_state = '0;

    task automatic model_reset();
        for (int i = 0; i < NK; i++) begin
            m_r1[i] = 1'b1; m_r2[i] = 1'b1; m_deb[i] = 1'b0;
            m_run[i] = 0;   m_hold[i] = 0;
        end
        m_press = '0; m_rel = '0; m_long = '0; m_state = '0;
    endtask

    task automatic model_step();
        m_press = '0; m_rel = '0; m_long = '0;
        for (int i = 0; i < NK; i++) begin
            bit p;
            p       = ~m_r2[i];
            m_r2[i] = m_r1[i];
            m_r1[i] = kif.key_in[i];
            if (!m_deb[i]) begin
                m_run[i] = p ? m_run[i] + 1 : 0;
                if (m_run[i] == DEB + 1) begin
                    m_deb[i] = 1'b1; m_press[i] = 1'b1; m_run[i] = 0; m_hold[i] = 0;
                end
            end else if (!p) begin
                m_run[i]++;
                if (m_run[i] == DEB + 1) begin
                    m_deb[i] = 1'b0; m_rel[i] = 1'b1; m_run[i] = 0;
                end
            end else begin
                if (m_run[i] == 0) begin
                    m_hold[i]++;
                    if (m_hold[i] == LNG - DEB) m_long[i] = 1'b1;
                end
                m_run[i] = 0;
            end
            m_state[i] = m_deb[i];
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (chk_en) begin
                n_tests++;
                if (kif.key_state !== m_state || kif.press_pulse !== m_press ||
                    kif.release_pulse !== m_rel || kif.long_pulse !== m_long) begin
                    n_fail++;
                    $display("FAIL model cyc %0d: got ks=%b pp=%b rp=%b lp=%b, expected ks=%b pp=%b rp=%b lp=%b",
                             cyc, kif.key_state, kif.press_pulse, kif.release_pulse, kif.long_pulse,
                             m_state, m_press, m_rel, m_long);
                end
            end
        end
    end

    // Stimulus schedule: sched[k] is the raw level sampled at edge k.
    logic [NK-1:0] sched[$];
    int f_press[NK], f_long[NK], f_rel[NK], f_ks[NK];
    int c_press[NK], c_long[NK], c_rel[NK];

    task automatic push(input logic [NK-1:0] v, input int n);
        for (int k = 0; k < n; k++) sched.push_back(v);
    endtask

    task automatic play();
        for (int i = 0; i < NK; i++) begin
            f_press[i] = -1; f_long[i] = -1; f_rel[i] = -1; f_ks[i] = -1;
            c_press[i] = 0;  c_long[i] = 0;  c_rel[i] = 0;
        end
        @(negedge clk);
        kif.key_in = sched[0];
        for (int k = 0; k < sched.size(); k++) begin
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < NK; i++) begin
                if (kif.press_pulse[i])   begin if (f_press[i] < 0) f_press[i] = k; c_press[i]++; end
                if (kif.long_pulse[i])    begin if (f_long[i]  < 0) f_long[i]  = k; c_long[i]++;  end
                if (kif.release_pulse[i]) begin if (f_rel[i]   < 0) f_rel[i]   = k; c_rel[i]++;   end
                if (kif.key_state[i] && f_ks[i] < 0) f_ks[i] = k;
            end
            if (k + 1 < sched.size()) kif.key_in = sched[k + 1];
        end
        sched.delete();
    endtask

    typedef struct {
        int ch;
        int low_len;
        int exp_press;
        int exp_long;
        int exp_rel;
    } vec_t;

    vec_t tbl[6];
    int   rem[NK];
    int   rp_first, rp_cnt;

    initial begin
        tbl[0] = '{0, 40, 10,  34, 50};
        tbl[1] = '{2,  7, -1,  -1, -1};
        tbl[2] = '{3,  8, -1,  -1, -1};
        tbl[3] = '{3,  9, 10,  -1, 19};
        tbl[4] = '{1, 32, 10,  -1, 42};
        tbl[5] = '{1, 33, 10,  34, 43};

        kif.key_in = '1;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset key_state",     int'(kif.key_state),     0);
        chk("reset press_pulse",   int'(kif.press_pulse),   0);
        chk("reset release_pulse", int'(kif.release_pulse), 0);
        chk("reset long_pulse",    int'(kif.long_pulse),    0);
        chk_en = 1'b1;
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int t = 0; t < 6; t++) begin
            logic [NK-1:0] v;
            int            ch;
            ch     = tbl[t].ch;
            v      = '1;
            v[ch]  = 1'b0;
            push(v, tbl[t].low_len);
            push('1, 20);
            play();
            chk($sformatf("tbl%0d press_at", t),  f_press[ch], tbl[t].exp_press);
            chk($sformatf("tbl%0d press_cnt", t), c_press[ch], int'(tbl[t].exp_press >= 0));
            chk($sformatf("tbl%0d long_at", t),   f_long[ch],  tbl[t].exp_long);
            chk($sformatf("tbl%0d rel_at", t),    f_rel[ch],   tbl[t].exp_rel);
            chk($sformatf("tbl%0d state_at", t),  f_ks[ch],    tbl[t].exp_press);
        end

        // Press bounce on channel 1: 3-cycle toggles, final fall at edge 30.
        for (int k = 0; k < 30; k++) push(((k / 3) % 2 == 0) ? 4'b1101 : 4'b1111, 1);
        push(4'b1101, 20);
        push('1, 20);
        play();
        chk("bounce press_at",  f_press[1], 40);
        chk("bounce press_cnt", c_press[1], 1);
        chk("bounce rel_cnt",   c_rel[1],   1);

        // Release bounce on channel 0: 2-cycle glitch, final rise at edge 46.
        push(4'b1110, 40);
        push('1, 4);
        push(4'b1110, 2);
        push('1, 20);
        play();
        chk("relbounce press_at", f_press[0], 10);
        chk("relbounce long_at",  f_long[0],  34);
        chk("relbounce long_cnt", c_long[0],  1);
        chk("relbounce rel_at",   f_rel[0],   56);
        chk("relbounce rel_cnt",  c_rel[0],   1);

        // Staggered presses on all channels.
        push(4'b1110, 1);
        push(4'b1100, 1);
        push(4'b1000, 1);
        push(4'b0000, 22);
        push('1, 20);
        play();
        for (int i = 0; i < NK; i++) begin
            chk($sformatf("indep ch%0d press_at", i),  f_press[i], 10 + i);
            chk($sformatf("indep ch%0d press_cnt", i), c_press[i], 1);
        end

        // Reset pulse while channel 2 is filtering a held press.
        @(negedge clk);
        kif.key_in = 4'b1011;
        repeat (5) begin @(posedge clk); @(negedge clk); end
        #1 rst_n = 1'b0;
        #1 chk("rst async outputs",
               int'({kif.key_state, kif.press_pulse, kif.release_pulse, kif.long_pulse}), 0);
        repeat (3) begin
            @(negedge clk);
            chk("rst held outputs",
                int'({kif.key_state, kif.press_pulse, kif.release_pulse, kif.long_pulse}), 0);
        end
        #1 rst_n = 1'b1;
        rp_first = -1;
        rp_cnt   = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (kif.press_pulse[2]) begin
                if (rp_first < 0) rp_first = k;
                rp_cnt++;
            end
        end
        chk("rst press_at",  rp_first, 10);
        chk("rst press_cnt", rp_cnt,   1);
        kif.key_in = '1;
        repeat (20) @(negedge clk);

        // Randomized activity, checked every cycle by the model.
        for (int i = 0; i < NK; i++) rem[i] = 1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < NK; i++) begin
                rem[i]--;
                if (rem[i] == 0) begin
                    kif.key_in[i] = ~kif.key_in[i];
                    rem[i] = ($urandom_range(0, 9) < 6) ? int'($urandom_range(1, 12))
                                                        : int'($urandom_range(9, 45));
                end
            end
            if (c == 1500) #1 rst_n = 1'b0;
            if (c == 1503) #1 rst_n = 1'b1;
        end
        @(negedge clk);
        kif.key_in = '1;
        repeat (30) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/key_debounce_array.md
KEY_DEBOUNCE_ARRAY -- requirements
Module: key_debounce_array

Interface
REQ-001 Parameter NUM_KEYS, default 4: number of independent key channels (1..32).
REQ-002 Parameter DEBOUNCE_CYC, default 1_000_000: required stable-level time in clk cycles (20 ms at 50 MHz).
REQ-003 Parameter LONG_CYC, default 50_000_000: debounced hold time for a long-press event (1 s at 50 MHz); SHALL be greater than DEBOUNCE_CYC.
REQ-004 Parameter ACTIVE_LOW, default 1: 1 = raw pressed level is 0; 0 = raw pressed level is 1.
REQ-005 clk  input  1  system clock.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 key_in  input  NUM_KEYS  raw, asynchronous key pins.
REQ-008 key_state  output  NUM_KEYS  debounced level per channel, 1 = pressed.
REQ-009 press_pulse  output  NUM_KEYS  one-cycle strobe on each debounced press.
REQ-010 release_pulse  output  NUM_KEYS  one-cycle strobe on each debounced release.
REQ-011 long_pulse  output  NUM_KEYS  one-cycle strobe when a press has been held LONG_CYC cycles.

Function
REQ-012 Each channel SHALL be fully independent; no output of channel i depends on key_in[j], j != i.
REQ-013 Each channel SHALL pass key_in through a 2-flop synchroniser, then normalise polarity per ACTIVE_LOW to p (1 = pressed).
REQ-014 Per-channel FSM states: IDLE, PRESS_FILT, DOWN, RELEASE_FILT (one-hot, 4 bits).
REQ-015 IDLE -> PRESS_FILT when p = 1; debounce counter cleared to 0.
REQ-016 PRESS_FILT: counter increments each cycle while p = 1; p = 0 before the count completes -> IDLE, no strobe.
REQ-017 PRESS_FILT -> DOWN in the cycle the counter reaches DEBOUNCE_CYC-1 with p = 1; press_pulse = 1 for that one cycle; key_state = 1 from the same cycle.
REQ-018 Press latency: press_pulse SHALL assert exactly DEBOUNCE_CYC+2 cycles after the first clk edge that samples the pressed raw level, given a stable input.
REQ-019 DOWN: hold counter increments each cycle, saturating; long_pulse = 1 for exactly one cycle when hold count reaches LONG_CYC-DEBOUNCE_CYC; at most one long_pulse per press.
REQ-020 DOWN -> RELEASE_FILT when p = 0; debounce counter cleared; hold counter retains its value.
REQ-021 RELEASE_FILT: p = 1 before the count completes -> DOWN, no strobe, hold counter resumes (bounce does not restart the long-press timer).
REQ-022 RELEASE_FILT -> IDLE when the counter reaches DEBOUNCE_CYC-1 with p = 0; release_pulse = 1 for one cycle; key_state = 0 from the same cycle; hold counter cleared.
REQ-023 Release latency: DEBOUNCE_CYC+2 cycles, symmetric with press.
REQ-024 Counter widths: $clog2(DEBOUNCE_CYC) and $clog2(LONG_CYC) bits; counters never wrap.
REQ-025 press_pulse, release_pulse, long_pulse SHALL be registered and never high for two consecutive cycles on one channel; press and release SHALL never coincide on one channel.
REQ-026 Illegal FSM encoding SHALL return to IDLE next cycle with all strobes 0 and key_state = 0.

Reset
REQ-027 During rst_n = 0: key_state, press_pulse, release_pulse, long_pulse all 0; FSMs IDLE; counters 0.
REQ-028 Synchroniser flops SHALL reset to the released raw level (1 if ACTIVE_LOW, else 0) so that release of reset never produces a false edge.
REQ-029 Reset asserted mid-filter or mid-hold SHALL abort immediately with no strobe; a key held through reset deassertion SHALL produce press_pulse DEBOUNCE_CYC+2 cycles later.

Structure
REQ-030 Shared package key_pkg SHALL hold the FSM state localparams (IDLE, PRESS_FILT, DOWN, RELEASE_FILT) and the default timing constants.
REQ-031 Sub-module key_debounce_ch SHALL implement one channel; key_debounce_array SHALL instantiate NUM_KEYS copies in a generate loop.

Verification (NUM_KEYS=4, DEBOUNCE_CYC=8, LONG_CYC=32, ACTIVE_LOW=1)
REQ-032 Clean press: key_in[0] 1->0 held 40 cycles -> press_pulse[0] at edge+10, long_pulse[0] at edge+34, one each; key_state[0] = 1 from edge+10.
REQ-033 Bounce: key_in[1] toggles every 3 cycles for 30 cycles, then stays 0 -> no strobe during bounce; single press_pulse[1] 10 cycles after the final transition.
REQ-034 Release bounce: held key released with one 2-cycle glitch back to 0 -> single release_pulse 10 cycles after the final rise; long_pulse timing unaffected.
REQ-035 Short press: key_in[2] low for 7 cycles -> no strobes, key_state[2] stays 0.
REQ-036 Independence: all four channels pressed at offsets 0,1,2,3 -> press_pulse bits assert at 10,11,12,13.
REQ-037 Reset: rst_n pulsed low during PRESS_FILT with key held -> outputs 0 during reset; press_pulse 10 cycles after rst_n rises.
